// File: rtl/sd_block_responder_if.sv
// Virtual-disk block handshake between a requester (master) and the responder (slave),
// including the sector-buffer port the responder drives.
interface sd_block_responder_if #(
  parameter int VDNUM = 3
);
  logic [31:0]      sd_lba;
  logic [VDNUM-1:0] sd_rd;
  logic [VDNUM-1:0] sd_wr;
  logic             sd_ack;
  logic [8:0]       sd_buff_addr;
  logic [7:0]       sd_buff_dout;
  logic             sd_buff_wr;
  logic [7:0]       sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/sd_block_responder.sv
// Serves 512-byte block reads/writes from a byte-wide backing memory, one image per drive.
// Optional write protect input img_wp is enabled by defining SD_BLOCK_RESPONDER_WRPROT_EN.
module sd_block_responder #(
  parameter int VDNUM  = 3,
  parameter int ADDR_W = 24,
  parameter int BLKS_W = 16
) (
  input  logic                    clk_sys,
  input  logic                    areset,
  sd_block_responder_if.slave     sd,
  input  logic [VDNUM*ADDR_W-1:0] img_base,
  input  logic [VDNUM*BLKS_W-1:0] img_blks,
`ifdef SD_BLOCK_RESPONDER_WRPROT_EN
  input  logic [VDNUM-1:0]        img_wp,
`endif
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [7:0]              mem_dout,
  input  logic [7:0]              mem_din,
  input  logic                    mem_ack
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_BUF, WR_BUF, WR_LAT, WR_MEM, DONE
  } state_t;

  state_t            state_q;
  logic [8:0]        cnt_q;
  logic              ack_q;
  logic [8:0]        buff_addr_q;
  logic [7:0]        buff_dout_q;
  logic              buff_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [7:0]        mem_dout_q;
  logic [ADDR_W-1:0] blk_addr_q;
  logic              skip_q;

  logic              req_d;
  logic              rd_d;
  logic              wp_d;
  logic [ADDR_W-1:0] base_d;
  logic [BLKS_W-1:0] blks_d;
  logic              oor_d;
  logic [ADDR_W-1:0] blk_addr_d;

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] blk,
                                                  input logic [8:0] idx);
    return blk + ADDR_W'(idx);
  endfunction

  // Descending scan so the lowest-index requesting drive is the one that sticks.
  always_comb begin
    req_d  = 1'b0;
    rd_d   = 1'b0;
    wp_d   = 1'b0;
    base_d = '0;
    blks_d = '0;
    for (int k = VDNUM - 1; k >= 0; k--) begin
      if (sd.sd_rd[k] | sd.sd_wr[k]) begin
        req_d  = 1'b1;
        rd_d   = sd.sd_rd[k];
        base_d = img_base[k*ADDR_W +: ADDR_W];
        blks_d = img_blks[k*BLKS_W +: BLKS_W];
`ifdef SD_BLOCK_RESPONDER_WRPROT_EN
        wp_d   = img_wp[k];
`endif
      end
    end
  end

  assign oor_d      = sd.sd_lba >= 32'(blks_d);
  assign blk_addr_d = base_d + ADDR_W'({sd.sd_lba, 9'b0});

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      buff_addr_q <= '0;
      buff_dout_q <= '0;
      buff_wr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_d) begin
            blk_addr_q  <= blk_addr_d;
            skip_q      <= oor_d | (~rd_d & wp_d);
            ack_q       <= 1'b1;
            cnt_q       <= '0;
            buff_addr_q <= '0;
            if (rd_d) begin
              state_q    <= RD_REQ;
              mem_rd_q   <= ~oor_d;
              mem_addr_q <= blk_addr_d;
            end else begin
              state_q    <= WR_BUF;
            end
          end
        end
        // Skipped blocks bypass memory and feed zeros into the buffer.
        RD_REQ: begin
          if (skip_q || (mem_rd_q && mem_ack)) begin
            mem_rd_q    <= 1'b0;
            buff_addr_q <= cnt_q;
            buff_dout_q <= skip_q ? 8'h00 : mem_din;
            buff_wr_q   <= 1'b1;
            state_q     <= RD_BUF;
          end
        end
        RD_BUF: begin
          buff_wr_q <= 1'b0;
          cnt_q     <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin
            state_q <= DONE;
            ack_q   <= 1'b0;
          end else begin
            state_q    <= RD_REQ;
            mem_rd_q   <= ~skip_q;
            mem_addr_q <= byte_addr(blk_addr_q, cnt_q + 9'd1);
          end
        end
        WR_BUF: state_q <= WR_LAT;
        WR_LAT: begin
          mem_dout_q <= sd.sd_buff_din;
          mem_wr_q   <= ~skip_q;
          mem_addr_q <= byte_addr(blk_addr_q, cnt_q);
          state_q    <= WR_MEM;
        end
        WR_MEM: begin
          if (skip_q || (mem_wr_q && mem_ack)) begin
            mem_wr_q <= 1'b0;
            cnt_q    <= cnt_q + 9'd1;
            if (cnt_q == 9'd511) begin
              state_q <= DONE;
              ack_q   <= 1'b0;
            end else begin
              buff_addr_q <= cnt_q + 9'd1;
              state_q     <= WR_BUF;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_addr = buff_addr_q;
  assign sd.sd_buff_dout = buff_dout_q;
  assign sd.sd_buff_wr   = buff_wr_q;
  assign mem_addr        = mem_addr_q;
  assign mem_rd          = mem_rd_q;
  assign mem_wr          = mem_wr_q;
  assign mem_dout        = mem_dout_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder with a latency-configurable backing memory and a
// registered sector-buffer model.
`timescale 1ns/1ps
module tb_sd_block_responder;
  localparam int VDNUM  = 3;
  localparam int ADDR_W = 24;
  localparam int BLKS_W = 16;

  logic clk_sys = 1'b0;
  logic areset;
  always #5 clk_sys = ~clk_sys;

  sd_block_responder_if #(.VDNUM(VDNUM)) sd_if ();

  logic [VDNUM*ADDR_W-1:0] img_base;
  logic [VDNUM*BLKS_W-1:0] img_blks;
`ifdef SD_BLOCK_RESPONDER_WRPROT_EN
  logic [VDNUM-1:0]        img_wp;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din = 8'h00;
  logic              mem_ack = 1'b0;

  sd_block_responder #(.VDNUM(VDNUM), .ADDR_W(ADDR_W), .BLKS_W(BLKS_W)) dut (
    .clk_sys  (clk_sys),
    .areset   (areset),
    .sd       (sd_if),
    .img_base (img_base),
    .img_blks (img_blks),
`ifdef SD_BLOCK_RESPONDER_WRPROT_EN
    .img_wp   (img_wp),
`endif
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack)
  );

  // Backing memory: mem[a] = a[7:0]; ack arrives mem_lat cycles after the request is seen.
  int   mem_lat  = 1;
  int   lat_left = 0;
  logic pend     = 1'b0;
  logic inj_ack  = 1'b0;
  always @(posedge clk_sys) begin
    mem_ack <= 1'b0;
    if (inj_ack) mem_ack <= 1'b1;
    else if (areset) pend <= 1'b0;
    else if (pend) begin
      if (lat_left <= 1) begin
        mem_ack <= 1'b1;
        mem_din <= mem_addr[7:0];
        pend    <= 1'b0;
      end else lat_left <= lat_left - 1;
    end else if ((mem_rd || mem_wr) && !mem_ack) begin
      pend     <= 1'b1;
      lat_left <= mem_lat;
    end
  end

  // Requester's sector buffer: read side holds ~i, registered with one cycle of latency.
  logic [7:0] bufsrc [512];
  logic [7:0] bufm   [512];
  always @(posedge clk_sys) sd_if.sd_buff_din <= bufsrc[sd_if.sd_buff_addr];

  int cyc = 0, bw_cnt = 0, bw_idx = 0, bw_ord_err = 0, last_bw_cyc = 0;
  int mrd_done = 0, mrd_cyc = 0, mrd_err = 0, rd_idx = 0;
  int mwr_done = 0, mwr_cyc = 0, mwr_err = 0, wr_idx = 0, stab_err = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic prev_ack = 1'b0, prev_rd = 1'b0, prev_mack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [ADDR_W-1:0] exp_mbase = '0;

  always @(negedge clk_sys) begin
    cyc++;
    if (sd_if.sd_ack && !prev_ack) begin
      rise_cyc = cyc; bw_idx = 0; rd_idx = 0; wr_idx = 0;
    end
    if (!sd_if.sd_ack && prev_ack) fall_cyc = cyc;
    if (sd_if.sd_buff_wr) begin
      bw_cnt++;
      last_bw_cyc = cyc;
      if (sd_if.sd_buff_addr != 9'(bw_idx)) bw_ord_err++;
      bufm[sd_if.sd_buff_addr] = sd_if.sd_buff_dout;
      bw_idx++;
    end
    if (mem_rd) mrd_cyc++;
    if (mem_wr) mwr_cyc++;
    if (mem_rd && mem_ack) begin
      mrd_done++;
      if (mem_addr != exp_mbase + ADDR_W'(rd_idx)) mrd_err++;
      rd_idx++;
    end
    if (mem_wr && mem_ack) begin
      mwr_done++;
      if (mem_addr != exp_mbase + ADDR_W'(wr_idx) || mem_dout != 8'(~wr_idx)) mwr_err++;
      wr_idx++;
    end
    if (mem_rd && prev_rd && !prev_mack && mem_addr != prev_addr) stab_err++;
    prev_ack = sd_if.sd_ack; prev_rd = mem_rd; prev_mack = mem_ack; prev_addr = mem_addr;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic val, input int budget, input string tag);
    int n = 0;
    while (sd_if.sd_ack !== val && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_ack_wait"}, 64'(sd_if.sd_ack), 64'(val));
  endtask

  task automatic run_xfer(input logic [2:0] rdm, input logic [2:0] wrm,
                          input logic [31:0] lba, input string tag);
    @(negedge clk_sys);
    sd_if.sd_lba = lba; sd_if.sd_rd = rdm; sd_if.sd_wr = wrm;
    wait_ack(1'b1, 20, tag);
    sd_if.sd_rd = '0; sd_if.sd_wr = '0;
    wait_ack(1'b0, 5000, tag);
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},       64'(sd_if.sd_ack),       64'd0);
    check({tag, "_buff_wr"},   64'(sd_if.sd_buff_wr),   64'd0);
    check({tag, "_buff_addr"}, 64'(sd_if.sd_buff_addr), 64'd0);
    check({tag, "_buff_dout"}, 64'(sd_if.sd_buff_dout), 64'd0);
    check({tag, "_mem_rd"},    64'(mem_rd),             64'd0);
    check({tag, "_mem_wr"},    64'(mem_wr),             64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),           64'd0);
    check({tag, "_mem_dout"},  64'(mem_dout),           64'd0);
  endtask

  function automatic int buf_bad_vs_index(input logic zero);
    int bad = 0;
    for (int i = 0; i < 512; i++)
      if (bufm[i] !== (zero ? 8'h00 : 8'(i))) bad++;
    return bad;
  endfunction

  initial begin
    int bw0, rc0, rcy0, wc0, wcy0, f1, r2;
    for (int i = 0; i < 512; i++) begin
      bufsrc[i] = 8'(~i);
      bufm[i]   = 8'hAA;
    end
    areset = 1'b1;
    sd_if.sd_lba = '0; sd_if.sd_rd = '0; sd_if.sd_wr = '0;
    img_base = {24'h010000, 24'h020000, 24'h001000};
    img_blks = {16'd8, 16'd4, 16'd16};
`ifdef SD_BLOCK_RESPONDER_WRPROT_EN
    img_wp = '0;
`endif
    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    areset = 1'b0;

    // In-range read, drive 0, lba 2
    exp_mbase = 24'h001400;
    bw0 = bw_cnt; rc0 = mrd_done; wcy0 = mwr_cyc;
    run_xfer(3'b001, 3'b000, 32'd2, "rd");
    check("rd_mem_done",   64'(mrd_done - rc0), 64'd512);
    check("rd_mem_addr",   64'(mrd_err),        64'd0);
    check("rd_addr_stab",  64'(stab_err),       64'd0);
    check("rd_buff_wr",    64'(bw_cnt - bw0),   64'd512);
    check("rd_buff_order", 64'(bw_ord_err),     64'd0);
    check("rd_buff_data",  64'(buf_bad_vs_index(1'b0)), 64'd0);
    check("rd_ack_fall",   64'(fall_cyc - last_bw_cyc), 64'd1);
    check("rd_no_mem_wr",  64'(mwr_cyc - wcy0), 64'd0);

    // In-range write, drive 2, lba 1
    exp_mbase = 24'h010200;
    bw0 = bw_cnt; wc0 = mwr_done; rcy0 = mrd_cyc;
    run_xfer(3'b000, 3'b100, 32'd1, "wr");
    check("wr_mem_done",  64'(mwr_done - wc0), 64'd512);
    check("wr_mem_addr",  64'(mwr_err),        64'd0);
    check("wr_no_buffwr", 64'(bw_cnt - bw0),   64'd0);
    check("wr_no_mem_rd", 64'(mrd_cyc - rcy0), 64'd0);

    // Last in-range block of drive 1
    exp_mbase = 24'h020600;
    rc0 = mrd_done;
    run_xfer(3'b010, 3'b000, 32'd3, "rd_last");
    check("rd_last_done", 64'(mrd_done - rc0), 64'd512);
    check("rd_last_addr", 64'(mrd_err),        64'd0);

    // Out-of-range read: zeros, no memory traffic, 2 cycles per byte
    bw0 = bw_cnt; rcy0 = mrd_cyc;
    run_xfer(3'b010, 3'b000, 32'd4, "oor_rd");
    check("oor_rd_no_mem", 64'(mrd_cyc - rcy0), 64'd0);
    check("oor_rd_buffwr", 64'(bw_cnt - bw0),   64'd512);
    check("oor_rd_zeros",  64'(buf_bad_vs_index(1'b1)), 64'd0);
    check("oor_rd_ackdur", 64'(fall_cyc - rise_cyc), 64'd1024);

    // Upper lba bits must take part in the range compare
    rcy0 = mrd_cyc;
    run_xfer(3'b010, 3'b000, 32'h0001_0002, "oor_rd_hi");
    check("oor_rd_hi_no_mem", 64'(mrd_cyc - rcy0), 64'd0);

    // Out-of-range write: buffer walked, no mem_wr, 3 cycles per byte
    wcy0 = mwr_cyc; bw0 = bw_cnt;
    run_xfer(3'b000, 3'b010, 32'd4, "oor_wr");
    check("oor_wr_no_mem", 64'(mwr_cyc - wcy0), 64'd0);
    check("oor_wr_ackdur", 64'(fall_cyc - rise_cyc), 64'd1536);
    check("oor_wr_no_bw",  64'(bw_cnt - bw0),   64'd0);

    // Arbitration: drive 0 read before drive 1 write; write waits DONE + idle
    exp_mbase = 24'h001400;
    rc0 = mrd_done; wc0 = mwr_done;
    @(negedge clk_sys);
    sd_if.sd_lba = 32'd2; sd_if.sd_rd = 3'b001; sd_if.sd_wr = 3'b010;
    wait_ack(1'b1, 20, "arb1");
    sd_if.sd_rd = 3'b000;
    wait_ack(1'b0, 5000, "arb1");
    exp_mbase = 24'h020400;
    @(negedge clk_sys);
    f1 = fall_cyc;
    check("arb_rd_first", 64'(mrd_done - rc0), 64'd512);
    check("arb_no_wr_yet", 64'(mwr_done - wc0), 64'd0);
    wc0 = mwr_done;
    wait_ack(1'b1, 20, "arb2");
    sd_if.sd_wr = 3'b000;
    @(negedge clk_sys);
    r2 = rise_cyc;
    check("arb_gap", 64'(r2 - f1), 64'd2);
    wait_ack(1'b0, 5000, "arb2");
    repeat (2) @(negedge clk_sys);
    check("arb_wr_done", 64'(mwr_done - wc0), 64'd512);
    check("arb_wr_addr", 64'(mwr_err),        64'd0);

    // Reset after 100 bytes of a read with latency 3, then a stale ack
    mem_lat = 3;
    exp_mbase = 24'h001400;
    bw0 = bw_cnt;
    @(negedge clk_sys);
    sd_if.sd_lba = 32'd2; sd_if.sd_rd = 3'b001;
    wait_ack(1'b1, 20, "rst_rd");
    sd_if.sd_rd = '0;
    for (int n = 0; n < 3000 && (bw_cnt - bw0) < 100; n++) @(negedge clk_sys);
    check("rst_100_bytes", 64'(bw_cnt - bw0), 64'd100);
    repeat (2) @(negedge clk_sys);
    check("rst_req_pending", 64'(mem_rd), 64'd1);
    areset = 1'b1;
    @(negedge clk_sys);
    check_outputs_zero("midrst");
    areset = 1'b0;
    bw0 = bw_cnt;
    inj_ack = 1'b1;
    @(negedge clk_sys);
    inj_ack = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("stale_ack_no_bw", 64'(bw_cnt - bw0), 64'd0);
    check("stale_ack_idle",  64'(sd_if.sd_ack), 64'd0);
    for (int i = 0; i < 512; i++) bufm[i] = 8'hAA;
    bw0 = bw_cnt; rc0 = mrd_done;
    run_xfer(3'b001, 3'b000, 32'd2, "rd_after_rst");
    check("rerd_buff_wr",   64'(bw_cnt - bw0),   64'd512);
    check("rerd_mem_done",  64'(mrd_done - rc0), 64'd512);
    check("rerd_order",     64'(bw_ord_err),     64'd0);
    check("rerd_data",      64'(buf_bad_vs_index(1'b0)), 64'd0);
    check("rerd_mem_addr",  64'(mrd_err),        64'd0);
    mem_lat = 1;

`ifdef SD_BLOCK_RESPONDER_WRPROT_EN
    // Write-protected drive 0: full walk at out-of-range timing, no mem_wr
    img_wp = 3'b001;
    wcy0 = mwr_cyc;
    run_xfer(3'b000, 3'b001, 32'd0, "wp");
    check("wp_no_mem_wr", 64'(mwr_cyc - wcy0), 64'd0);
    check("wp_ackdur",    64'(fall_cyc - rise_cyc), 64'd1536);
    img_wp = 3'b000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
